// File: rtl/ipsl_pcie_dma_wr_ctrl.sv
// DMA write controller: realigns a DW-packed 128-bit payload stream onto BAR RAM words with byte enables.
// Optional macro PCIE_DMA_WR_LAST_CHK_EN enables i_wr_last framing checks reported on o_wr_err.
module ipsl_pcie_dma_wr_ctrl #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_start,
    input  logic [9:0]            i_wr_length,
    input  logic [63:0]           i_wr_addr,
    input  logic [127:0]          i_wr_data,
    input  logic                  i_wr_valid,
    input  logic                  i_wr_last,
    output logic                  o_wr_ready,
    output logic                  o_bar_wr_en,
    output logic [ADDR_WIDTH-1:0] o_bar_wr_addr,
    output logic [127:0]          o_bar_wr_data,
    output logic [15:0]           o_bar_wr_byte_en,
    output logic                  o_wr_busy,
    output logic                  o_wr_done,
    output logic                  o_wr_err
);
    typedef enum logic [1:0] {IDLE, DATA, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [10:0]           len_q, len_d;
    logic [1:0]            p_q, p_d;
    logic [8:0]            in_beats_q, in_beats_d;
    logic [8:0]            out_beats_q, out_beats_d;
    logic [8:0]            in_cnt_q, in_cnt_d;
    logic [8:0]            out_cnt_q, out_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [127:0]          prev_q, prev_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [127:0]          wr_data_q, wr_data_d;
    logic [15:0]           wr_be_q, wr_be_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [10:0] start_len;
    logic [11:0] start_span;
    logic        last_in;
    logic        unused_bits;

    // Output beat = ({cur,prev} >> (128 - 32p))[127:0]
    function automatic logic [127:0] realign(input logic [127:0] cur, input logic [127:0] prev,
                                             input logic [1:0] p);
        logic [127:0] r;
        case (p)
            2'd0:    r = cur;
            2'd1:    r = {cur[95:0], prev[127:96]};
            2'd2:    r = {cur[63:0], prev[127:64]};
            default: r = {cur[31:0], prev[127:32]};
        endcase
        return r;
    endfunction

    function automatic logic [15:0] beat_be(input logic [8:0] k, input logic [1:0] p,
                                            input logic [10:0] len);
        logic [11:0] pos, lo, hi;
        logic [15:0] be;
        lo = {10'd0, p};
        hi = lo + {1'b0, len};
        be = 16'h0000;
        for (int d = 0; d < 4; d++) begin
            pos = {1'b0, k, 2'b00} + 12'(d);
            be[4*d +: 4] = (pos >= lo && pos < hi) ? 4'hF : 4'h0;
        end
        return be;
    endfunction

    assign start_len   = (i_wr_length == 10'd0) ? 11'd1024 : {1'b0, i_wr_length};
    assign start_span  = {1'b0, start_len} + {10'd0, i_wr_addr[3:2]};
    assign unused_bits = ^{i_wr_addr[63:ADDR_WIDTH+4], i_wr_addr[1:0], i_wr_last};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        p_d         = p_q;
        in_beats_d  = in_beats_q;
        out_beats_d = out_beats_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        addr_d      = addr_q;
        prev_d      = prev_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_be_d     = wr_be_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        last_in     = (in_cnt_q == in_beats_q - 9'd1);
        case (state_q)
            IDLE: begin
                if (i_wr_start) begin
                    len_d       = start_len;
                    p_d         = i_wr_addr[3:2];
                    in_beats_d  = 9'((start_len + 11'd3) >> 2);
                    out_beats_d = 9'((start_span + 12'd3) >> 2);
                    in_cnt_d    = 9'd0;
                    out_cnt_d   = 9'd0;
                    addr_d      = i_wr_addr[ADDR_WIDTH+3:4];
                    prev_d      = 128'd0;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (i_wr_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = realign(i_wr_data, prev_q, p_q);
                    wr_be_d   = beat_be(out_cnt_q, p_q, len_q);
                    addr_d    = addr_q + 1'b1;
                    prev_d    = i_wr_data;
                    in_cnt_d  = in_cnt_q + 9'd1;
                    out_cnt_d = out_cnt_q + 9'd1;
                    if (last_in) begin
                        if (out_beats_q > in_beats_q) begin
                            state_d = FLUSH;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
`ifdef PCIE_DMA_WR_LAST_CHK_EN
                    // Early last terminates without flush; missing last only flags the error
                    if (i_wr_last && !last_in) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (last_in && !i_wr_last) begin
                        err_d = 1'b1;
                    end
`endif
                end
            end
            FLUSH: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = realign(128'd0, prev_q, p_q);
                wr_be_d   = beat_be(out_cnt_q, p_q, len_q);
                addr_d    = addr_q + 1'b1;
                out_cnt_d = out_cnt_q + 9'd1;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            p_q         <= '0;
            in_beats_q  <= '0;
            out_beats_q <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            addr_q      <= '0;
            prev_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_be_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            p_q         <= p_d;
            in_beats_q  <= in_beats_d;
            out_beats_q <= out_beats_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            addr_q      <= addr_d;
            prev_q      <= prev_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_be_q     <= wr_be_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign o_wr_ready       = (state_q == DATA);
    assign o_bar_wr_en      = wr_en_q;
    assign o_bar_wr_addr    = wr_addr_q;
    assign o_bar_wr_data    = wr_data_q;
    assign o_bar_wr_byte_en = wr_be_q;
    assign o_wr_busy        = (state_q != IDLE) | wr_en_q;
    assign o_wr_done        = done_q;
    assign o_wr_err         = err_q;
endmodule

// File: doc/ipsl_pcie_dma_wr_ctrl.md
# ipsl_pcie_dma_wr_ctrl

Write-side counterpart of the DMA read controller. It accepts a DW-packed 128-bit payload stream from the TLP receive path (MWr payload or CplD data) and writes it into the BAR RAM. Each DW is realigned to its destination address offset, and byte enables are generated for partial first and last beats. The block sits between the RX TLP decoder and the BAR RAM write port.

## Interface
- `ADDR_WIDTH`, default 9: BAR RAM word (128-bit) address width.
- `clk` in 1: single clock (gen1 62.5 MHz, gen2 125 MHz).
- `rst` in 1: synchronous, active-high reset.
- `i_wr_start` in 1: transfer request pulse; sampled only in IDLE.
- `i_wr_length` in 10: transfer length in DW; 0 encodes 1024.
- `i_wr_addr` in 64: destination byte address. Bits [3:2] give the DW offset p; bits [ADDR_WIDTH+3:4] give the RAM word.
- `i_wr_data` in 128: payload beat, DW0 in [31:0], packed from the first DW.
- `i_wr_valid` in 1: payload beat valid.
- `i_wr_last` in 1: final payload beat marker.
- `o_wr_ready` out 1: payload accept.
- `o_bar_wr_en` out 1: RAM write strobe.
- `o_bar_wr_addr` out ADDR_WIDTH: RAM word address.
- `o_bar_wr_data` out 128: realigned write data.
- `o_bar_wr_byte_en` out 16: byte enables; bit i covers byte i.
- `o_wr_busy` out 1: transfer in progress.
- `o_wr_done` out 1: one-cycle pulse, coincident with the final RAM write.
- `o_wr_err` out 1: one-cycle framing error pulse.

## Operation
- FSM states: IDLE, DATA, FLUSH.
- IDLE:
  - `i_wr_start` latches L = length (11-bit, 0→1024), p, and the start word address.
  - Computes in_beats = ceil(L/4) and out_beats = ceil((L+p)/4).
  - Clears the previous-beat register to 0; goes to DATA.
- DATA:
  - `o_wr_ready`=1. Each beat is accepted on valid&ready.
  - The accepted beat becomes cur; the beat accepted before it is prev.
  - Output data = ({cur,prev} >> (128−32p))[127:0]. For p=0 this is cur; for p=1 it is {cur[95:0],prev[127:96]}.
- Byte enables: DW d of output beat k is enabled iff p ≤ 4k+d < p+L. Each enabled DW drives 4'hF.
- Address: starts at i_wr_addr[ADDR_WIDTH+3:4] and increments by 1 per RAM write. It wraps modulo 2^ADDR_WIDTH.
- After the in_beats-th beat is accepted:
  - If out_beats > in_beats, go to FLUSH. The flush beat uses cur=0 and prev=last beat.
  - Otherwise go to IDLE.
- FLUSH lasts one cycle with `o_wr_ready`=0, then goes to IDLE.
- `o_wr_done` is asserted together with the write of output beat out_beats−1.
- `i_wr_start` outside IDLE is ignored.
- Input beats outside DATA are not accepted (`o_wr_ready`=0).
- `o_wr_busy` = (state≠IDLE) | `o_bar_wr_en`.

## Timing
- All outputs except `o_wr_ready` are registered. `o_wr_ready` = (state==DATA).
- Reset values: all outputs 0; state IDLE; address, counters and prev register cleared.
- Start latency: `i_wr_start` at cycle t gives `o_wr_ready`=1 at t+1.
- A beat accepted at cycle t is written at t+1.
- The flush write appears 2 cycles after the last beat is accepted.
- Back-to-back transfers: a new `i_wr_start` is accepted in the cycle state returns to IDLE. The final write of the previous transfer may still be on the outputs in that cycle.
- Gaps in `i_wr_valid` insert no writes; the address holds.
- Reset mid-transfer:
  - Aborts immediately with no further writes and no `o_wr_done`.
  - Partially written RAM content stays as written.

## Configuration
- `PCIE_DMA_WR_LAST_CHK_EN` defined:
  - Early last: `i_wr_last` on an accepted beat before beat in_beats terminates the transfer. That beat is written, no flush occurs, and `o_wr_done` and `o_wr_err` pulse with that write.
  - Missing last: the in_beats-th beat accepted without `i_wr_last` pulses `o_wr_err` with its write. The transfer then completes normally, including any flush.
- `PCIE_DMA_WR_LAST_CHK_EN` undefined: `i_wr_last` is ignored and `o_wr_err` is tied 0.

## Test plan
- L=8, addr=0x100, 2 beats → writes to word 0x10 and 0x11. BE 16'hFFFF both, data unshifted. `o_wr_done` with the 2nd write.
- L=5, addr=0x20C (p=3), beats A,B → word 0x20: data {A[31:0],96'h0}, BE 16'hF000. Word 0x21: data {B[31:0],A[127:32]}, BE 16'hFFFF. No flush.
- L=4, p=1, single beat A → word W: data {A[95:0],32'h0}, BE 16'hFFF0. Flush at W+1: data {96'h0,A[127:96]}, BE 16'h000F, 2 cycles after the accept, with `o_wr_done`.
- L=0 (1024 DW), ADDR_WIDTH=9, start word 0x1F0, with random `i_wr_valid` gaps → 256 writes, last at word 0x0EF. No writes during gaps.
- Reset asserted after 3 of 8 beats → exactly 3 writes, no `o_wr_done`. Next `i_wr_start` after reset is accepted normally.
- Macro defined, L=12, `i_wr_last` on beat 2 → 2 writes; `o_wr_err`=`o_wr_done`=1 on the 2nd; FSM back in IDLE.
